// File: rtl/tdisto_engine_if.sv
// Job/beat bus of the Hadamard distortion engine: job control, block-pair stream and result.
// A pair transfers on a rising edge where in_valid and in_ready are both high; the source holds data steady while in_valid waits for in_ready.
interface tdisto_engine_if #(
    parameter int NB_W      = 4,
    parameter int W_WIDTH   = 16,
    parameter int SUM_WIDTH = 32
);
    logic                   start;
    logic [NB_W-1:0]        blk_m1;
    logic [16*W_WIDTH-1:0]  w;
    logic                   in_valid;
    logic                   in_ready;
    logic [127:0]           in_a;
    logic [127:0]           in_b;
    logic [SUM_WIDTH-1:0]   disto;
    logic                   done;
    logic                   busy;
    logic [1:0]             state_dbg;

    modport master (
        output start, blk_m1, w, in_valid, in_a, in_b,
        input  in_ready, disto, done, busy, state_dbg
    );

    modport slave (
        input  start, blk_m1, w, in_valid, in_a, in_b,
        output in_ready, disto, done, busy, state_dbg
    );
endinterface

// File: rtl/tdisto_engine.sv
// Streaming 4x4 Walsh-Hadamard weighted distortion engine.
// Three-stage pipeline per block pair (WHT/abs, weighted sum, difference/accumulate) under a job FSM.
module tdisto_engine #(
    parameter int NB_W      = 4,
    parameter int W_WIDTH   = 16,
    parameter int SUM_WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    tdisto_engine_if.slave bus
);
    localparam int PROD_W = 12 + W_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [16*W_WIDTH-1:0]        w_q;
    logic [NB_W-1:0]              blk_q;
    logic [NB_W-1:0]              cnt_q;
    logic                         accept;
    logic                         last_beat;
    logic                         s1_valid;
    logic [16*12-1:0]             s1_abs_a;
    logic [16*12-1:0]             s1_abs_b;
    logic                         s2_valid;
    logic signed [SUM_WIDTH-1:0]  s2_sum_a;
    logic signed [SUM_WIDTH-1:0]  s2_sum_b;
    logic signed [SUM_WIDTH:0]    diff;
    logic [SUM_WIDTH:0]           diff_mag;
    logic [SUM_WIDTH-1:0]         blk_d;
    logic [SUM_WIDTH-1:0]         acc_q;
    logic [SUM_WIDTH-1:0]         disto_q;

    // Row terms reach 1020 and column terms 4080 for an all-255 block, so the
    // butterflies carry one bit of headroom over the nominal 10/12-bit signed widths.
    function automatic logic [16*12-1:0] wht_abs(input logic [127:0] px);
        logic signed [10:0] row [16];
        logic signed [10:0] p0, p1, p2, p3, a0, a1, a2, a3;
        logic signed [12:0] q0, q1, q2, q3, b0, b1, b2, b3;
        logic signed [12:0] c [4];
        logic signed [12:0] mag;
        logic [16*12-1:0]   res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            p0 = $signed({3'b000, px[8*(4*r+0) +: 8]});
            p1 = $signed({3'b000, px[8*(4*r+1) +: 8]});
            p2 = $signed({3'b000, px[8*(4*r+2) +: 8]});
            p3 = $signed({3'b000, px[8*(4*r+3) +: 8]});
            a0 = p0 + p2;
            a1 = p1 + p3;
            a2 = p1 - p3;
            a3 = p0 - p2;
            row[4*r+0] = a0 + a1;
            row[4*r+1] = a3 + a2;
            row[4*r+2] = a3 - a2;
            row[4*r+3] = a0 - a1;
        end
        for (int j = 0; j < 4; j++) begin
            q0 = {{2{row[j][10]}},    row[j]};
            q1 = {{2{row[4+j][10]}},  row[4+j]};
            q2 = {{2{row[8+j][10]}},  row[8+j]};
            q3 = {{2{row[12+j][10]}}, row[12+j]};
            b0 = q0 + q2;
            b1 = q1 + q3;
            b2 = q1 - q3;
            b3 = q0 - q2;
            c[0] = b0 + b1;
            c[1] = b3 + b2;
            c[2] = b3 - b2;
            c[3] = b0 - b1;
            for (int i = 0; i < 4; i++) begin
                mag = c[i][12] ? -c[i] : c[i];
                res[12*(4*i+j) +: 12] = mag[11:0];
            end
        end
        return res;
    endfunction

    function automatic logic signed [SUM_WIDTH-1:0] weighted_sum(
        input logic [16*12-1:0]      ab,
        input logic [16*W_WIDTH-1:0] wv
    );
        logic signed [PROD_W-1:0]    prod;
        logic signed [SUM_WIDTH-1:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) begin
            prod = PROD_W'($signed({1'b0, ab[12*k +: 12]})) *
                   PROD_W'($signed(wv[W_WIDTH*k +: W_WIDTH]));
            s = s + SUM_WIDTH'(prod);
        end
        return s;
    endfunction

    assign accept    = bus.in_valid && (state_q == RUN);
    assign last_beat = accept && (cnt_q == blk_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_beat) state_d = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_abs_a <= '0;
            s1_abs_b <= '0;
            s2_valid <= 1'b0;
            s2_sum_a <= '0;
            s2_sum_b <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_abs_a <= wht_abs(bus.in_a);
                s1_abs_b <= wht_abs(bus.in_b);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum_a <= weighted_sum(s1_abs_a, w_q);
                s2_sum_b <= weighted_sum(s1_abs_b, w_q);
            end
        end
    end

    // Widen by one bit so the difference of two extreme sums cannot wrap.
    always_comb begin
        diff     = {s2_sum_b[SUM_WIDTH-1], s2_sum_b} - {s2_sum_a[SUM_WIDTH-1], s2_sum_a};
        diff_mag = diff[SUM_WIDTH] ? -diff : diff;
        blk_d    = SUM_WIDTH'(diff_mag >> 5);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            disto_q <= '0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                w_q   <= bus.w;
                blk_q <= bus.blk_m1;
                cnt_q <= '0;
                acc_q <= '0;
            end else begin
                if (accept)   cnt_q <= cnt_q + 1'b1;
                if (s2_valid) acc_q <= acc_q + blk_d;
            end
            if (state_q == DRAIN && state_d == DONE) disto_q <= acc_q;
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.disto     = disto_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_tdisto_engine.sv
// Self-checking bench for tdisto_engine: per-scenario tasks plus a done-triggered scoreboard
// fed from an integer reference model of the weighted Hadamard distortion.
module tb_tdisto_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0]  exp_q[$];
    logic [31:0]  exp_v;
    logic [127:0] blk_a [16];
    logic [127:0] blk_b [16];

    tdisto_engine_if #(.NB_W(4), .W_WIDTH(16), .SUM_WIDTH(32)) bus ();

    tdisto_engine #(.NB_W(4), .W_WIDTH(16), .SUM_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    // Scoreboard: every done pulse consumes one expected job result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got=1 exp=0 disto=%0d", bus.disto);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.disto !== exp_v) begin
                    failures++;
                    $display("FAIL disto_scoreboard got=%0d exp=%0d", bus.disto, exp_v);
                end
            end
        end
    end

    // Reference: plain-integer 4x4 WHT, |coef|, weighted sum.
    function automatic longint model_sum(input logic [127:0] px, input logic [255:0] wv);
        int m [16];
        int t [16];
        int p0, p1, p2, p3, c;
        longint s;
        for (int i = 0; i < 16; i++) m[i] = int'(px[8*i +: 8]);
        for (int r = 0; r < 4; r++) begin
            p0 = m[4*r]; p1 = m[4*r+1]; p2 = m[4*r+2]; p3 = m[4*r+3];
            t[4*r+0] = (p0 + p2) + (p1 + p3);
            t[4*r+1] = (p0 - p2) + (p1 - p3);
            t[4*r+2] = (p0 - p2) - (p1 - p3);
            t[4*r+3] = (p0 + p2) - (p1 + p3);
        end
        for (int j = 0; j < 4; j++) begin
            p0 = t[j]; p1 = t[4+j]; p2 = t[8+j]; p3 = t[12+j];
            m[j]    = (p0 + p2) + (p1 + p3);
            m[4+j]  = (p0 - p2) + (p1 - p3);
            m[8+j]  = (p0 - p2) - (p1 - p3);
            m[12+j] = (p0 + p2) - (p1 + p3);
        end
        s = 0;
        for (int k = 0; k < 16; k++) begin
            c = (m[k] < 0) ? -m[k] : m[k];
            s += longint'(c) * longint'($signed(wv[16*k +: 16]));
        end
        return s;
    endfunction

    function automatic logic [31:0] model_job(input int nblk, input logic [255:0] wv);
        longint d;
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < nblk; i++) begin
            d = model_sum(blk_b[i], wv) - model_sum(blk_a[i], wv);
            if (d < 0) d = -d;
            acc = acc + 32'(d >> 5);
        end
        return acc;
    endfunction

    function automatic logic [127:0] rand_px();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand_w();
        logic [255:0] wv;
        for (int k = 0; k < 16; k++) wv[16*k +: 16] = 16'($urandom_range(0, 65535));
        return wv;
    endfunction

    // Drives one whole job from blk_a/blk_b and checks handshake timing around the end.
    task automatic run_job(input int nblk, input logic [255:0] wv, input int gap_max,
                           input bit disturb, input logic [31:0] expv);
        int n;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.blk_m1 = 4'(nblk - 1);
        bus.w      = wv;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ack got=%b%b exp=11", bus.busy, bus.in_ready);
        end
        for (int i = 0; i < nblk; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_a     = blk_a[i];
            bus.in_b     = blk_b[i];
            if (disturb) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.w     = rand_w();
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_last got=%b busy=%b exp=0 busy=1", bus.in_ready, bus.busy);
        end
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL done_latency got=%0d exp=4 (negedges after last beat)", n);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL busy_fall got=%b%b exp=00", bus.busy, bus.done);
        end
    endtask

    function automatic logic [255:0] dc_w(input logic [15:0] w0);
        logic [255:0] wv;
        wv = '0;
        wv[15:0] = w0;
        return wv;
    endfunction

    task automatic fill_dc(input int nblk);
        for (int i = 0; i < nblk; i++) begin
            blk_a[i] = {128{1'b1}};
            blk_b[i] = '0;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.blk_m1 = '0; bus.w = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.done, bus.busy} !== 3'b000 || bus.disto !== 32'd0 || bus.state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL reset_values got=rdy%b done%b busy%b disto%0d st%0d exp=all zero",
                     bus.in_ready, bus.done, bus.busy, bus.disto, bus.state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        for (int r = 0; r < 3; r++) begin
            blk_a[0] = rand_px();
            blk_b[0] = blk_a[0];
            run_job(1, rand_w(), 0, 1'b0, 32'd0);
        end
    endtask

    task automatic test_dc();
        fill_dc(1);
        run_job(1, dc_w(16'd1), 0, 1'b0, 32'd127);
        run_job(1, dc_w(16'hFFFF), 0, 1'b0, 32'd127);
    endtask

    task automatic test_flat();
        blk_a[0] = 128'd32;
        blk_b[0] = '0;
        run_job(1, {16{16'd1}}, 0, 1'b0, 32'd16);
    endtask

    task automatic test_multi_block();
        fill_dc(16);
        run_job(16, dc_w(16'd1), 1, 1'b0, 32'd2032);
    endtask

    task automatic test_protocol();
        fill_dc(16);
        bus.in_valid = 1'b1;
        bus.in_a = blk_a[0];
        bus.in_b = blk_b[0];
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL valid_in_idle got=busy%b rdy%b exp=busy0 rdy0", bus.busy, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        run_job(16, dc_w(16'd1), 2, 1'b1, 32'd2032);
    endtask

    task automatic test_random();
        int nblk;
        logic [255:0] wv;
        for (int r = 0; r < 6; r++) begin
            nblk = $urandom_range(1, 16);
            wv = rand_w();
            for (int i = 0; i < nblk; i++) begin
                blk_a[i] = rand_px();
                blk_b[i] = rand_px();
            end
            run_job(nblk, wv, (r % 2 == 0) ? 0 : 2, 1'b0, model_job(nblk, wv));
        end
    endtask

    task automatic test_reset_mid();
        fill_dc(16);
        @(negedge clk);
        bus.start = 1'b1; bus.blk_m1 = 4'd15; bus.w = dc_w(16'd1);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_a = blk_a[i]; bus.in_b = blk_b[i];
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.done, bus.busy} !== 3'b000 || bus.disto !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_job got=rdy%b done%b busy%b disto%0d exp=all zero",
                     bus.in_ready, bus.done, bus.busy, bus.disto);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0", bus.busy);
        end
        fill_dc(1);
        run_job(1, dc_w(16'd1), 0, 1'b0, 32'd127);
        for (int i = 0; i < 3; i++) begin
            blk_a[i] = 128'd32;
            blk_b[i] = '0;
        end
        run_job(3, {16{16'd1}}, 0, 1'b0, 32'd48);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_dc();
        test_flat();
        test_multi_block();
        test_protocol();
        test_random();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL results_pending got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
